cavlc_field_sched: RTL and testbench

- Sequencer between the CAVLC encoder stage and the bitstream packer.
- Captures one 4x4 block's five encoded syntax fields in one handshake: coeff_token, trailing-ones signs, level codes, total_zeros, run_before.
- Issues the fields one at a time, in H.264 syntax order, over a single shared packer port, skipping absent fields.
- Reports completion of each block together with its topleft position.

---
 rtl/cavlc_field_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_cavlc_field_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_field_sched.sv
// CAVLC field sequencer: captures one block's five coded fields and issues them in syntax order to the packer.
// Optional CAVLC_FIELD_BITCNT_EN adds per-block (blk_bits) and running (total_bits) bit counters.
module cavlc_field_sched #(
    parameter int CODE_W = 50,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [9:0]        topleft_x,
    input  logic [9:0]        topleft_y,
    input  logic [15:0]       ct_code,
    input  logic [4:0]        ct_bit,
    input  logic              ct_vld,
    input  logic [2:0]        t1_code,
    input  logic [3:0]        t1_bit,
    input  logic              t1_vld,
    input  logic [49:0]       lv_code,
    input  logic [5:0]        lv_bit,
    input  logic              lv_vld,
    input  logic [8:0]        tz_code,
    input  logic [3:0]        tz_bit,
    input  logic              tz_vld,
    input  logic [24:0]       rb_code,
    input  logic [4:0]        rb_bit,
    input  logic              rb_vld,
    output logic              pk_valid,
    input  logic              pk_ready,
    output logic [CODE_W-1:0] pk_code,
    output logic [LEN_W-1:0]  pk_len,
    output logic              blk_done,
    output logic [9:0]        blk_x,
    output logic [9:0]        blk_y
`ifdef CAVLC_FIELD_BITCNT_EN
    ,
    output logic [9:0]        blk_bits,
    output logic [31:0]       total_bits
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_CT, S_T1, S_LV, S_TZ, S_RB} state_t;

    state_t            r_state;
    logic              r_rdy;
    logic [4:0]        r_mask;
    logic [2:0]        r_t1_code;
    logic [3:0]        r_t1_bit;
    logic [49:0]       r_lv_code;
    logic [5:0]        r_lv_bit;
    logic [8:0]        r_tz_code;
    logic [3:0]        r_tz_bit;
    logic [24:0]       r_rb_code;
    logic [4:0]        r_rb_bit;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic              r_pk_valid;
    logic [CODE_W-1:0] r_pk_code;
    logic [LEN_W-1:0]  r_pk_len;
    logic              r_done;
    logic [9:0]        r_bx;
    logic [9:0]        r_by;

    logic [4:0]        w_in_mask;
    logic [4:0]        w_cap_rem;
    logic [4:0]        w_nxt_rem;
    logic              w_cap;
    logic              w_xfer;
    state_t            w_cap_st;
    logic [CODE_W-1:0] w_cap_code;
    logic [LEN_W-1:0]  w_cap_len;
    state_t            w_nxt_st;
    logic [CODE_W-1:0] w_nxt_code;
    logic [LEN_W-1:0]  w_nxt_len;

    assign w_in_mask = {rb_vld && (rb_bit != '0), tz_vld && (tz_bit != '0),
                        lv_vld && (lv_bit != '0), t1_vld && (t1_bit != '0),
                        ct_vld && (ct_bit != '0)};
    assign w_cap     = enc_valid && r_rdy && (r_state == S_IDLE);
    assign w_xfer    = r_pk_valid && pk_ready;
    // Clearing the lowest set bit leaves the fields still to be issued.
    assign w_cap_rem = w_in_mask & (w_in_mask - 5'd1);
    assign w_nxt_rem = r_mask & (r_mask - 5'd1);

    always_comb begin
        w_cap_st   = S_IDLE;
        w_cap_code = '0;
        w_cap_len  = '0;
        if (w_in_mask[0]) begin
            w_cap_st   = S_CT;
            w_cap_code = CODE_W'(ct_code);
            w_cap_len  = LEN_W'(ct_bit);
        end else if (w_in_mask[1]) begin
            w_cap_st   = S_T1;
            w_cap_code = CODE_W'(t1_code);
            w_cap_len  = LEN_W'(t1_bit);
        end else if (w_in_mask[2]) begin
            w_cap_st   = S_LV;
            w_cap_code = CODE_W'(lv_code);
            w_cap_len  = LEN_W'(lv_bit);
        end else if (w_in_mask[3]) begin
            w_cap_st   = S_TZ;
            w_cap_code = CODE_W'(tz_code);
            w_cap_len  = LEN_W'(tz_bit);
        end else if (w_in_mask[4]) begin
            w_cap_st   = S_RB;
            w_cap_code = CODE_W'(rb_code);
            w_cap_len  = LEN_W'(rb_bit);
        end
    end

    always_comb begin
        w_nxt_st   = S_IDLE;
        w_nxt_code = '0;
        w_nxt_len  = '0;
        if (r_mask[1]) begin
            w_nxt_st   = S_T1;
            w_nxt_code = CODE_W'(r_t1_code);
            w_nxt_len  = LEN_W'(r_t1_bit);
        end else if (r_mask[2]) begin
            w_nxt_st   = S_LV;
            w_nxt_code = CODE_W'(r_lv_code);
            w_nxt_len  = LEN_W'(r_lv_bit);
        end else if (r_mask[3]) begin
            w_nxt_st   = S_TZ;
            w_nxt_code = CODE_W'(r_tz_code);
            w_nxt_len  = LEN_W'(r_tz_bit);
        end else if (r_mask[4]) begin
            w_nxt_st   = S_RB;
            w_nxt_code = CODE_W'(r_rb_code);
            w_nxt_len  = LEN_W'(r_rb_bit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rdy      <= 1'b0;
            r_mask     <= '0;
            r_t1_code  <= '0;
            r_t1_bit   <= '0;
            r_lv_code  <= '0;
            r_lv_bit   <= '0;
            r_tz_code  <= '0;
            r_tz_bit   <= '0;
            r_rb_code  <= '0;
            r_rb_bit   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_pk_valid <= 1'b0;
            r_pk_code  <= '0;
            r_pk_len   <= '0;
            r_done     <= 1'b0;
            r_bx       <= '0;
            r_by       <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_rdy <= !(w_cap && (w_in_mask != '0));
                if (w_cap) begin
                    r_t1_code  <= t1_code;
                    r_t1_bit   <= t1_bit;
                    r_lv_code  <= lv_code;
                    r_lv_bit   <= lv_bit;
                    r_tz_code  <= tz_code;
                    r_tz_bit   <= tz_bit;
                    r_rb_code  <= rb_code;
                    r_rb_bit   <= rb_bit;
                    r_x        <= topleft_x;
                    r_y        <= topleft_y;
                    r_mask     <= w_cap_rem;
                    r_state    <= w_cap_st;
                    r_pk_valid <= (w_in_mask != '0);
                    r_pk_code  <= w_cap_code;
                    r_pk_len   <= w_cap_len;
                    if (w_in_mask == '0) begin
                        r_done <= 1'b1;
                        r_bx   <= topleft_x;
                        r_by   <= topleft_y;
                    end
                end
            end else if (w_xfer) begin
                r_mask    <= w_nxt_rem;
                r_state   <= w_nxt_st;
                r_pk_code <= w_nxt_code;
                r_pk_len  <= w_nxt_len;
                if (r_mask == '0) begin
                    r_pk_valid <= 1'b0;
                    r_done     <= 1'b1;
                    r_bx       <= r_x;
                    r_by       <= r_y;
                    r_rdy      <= 1'b1;
                end
            end
        end
    end

`ifdef CAVLC_FIELD_BITCNT_EN
    logic [9:0]  r_acc;
    logic [9:0]  r_blk_bits;
    logic [31:0] r_tot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_blk_bits <= '0;
            r_tot      <= '0;
        end else if (w_cap && (w_in_mask == '0)) begin
            r_blk_bits <= '0;
        end else if (w_xfer) begin
            r_tot <= r_tot + 32'(r_pk_len);
            if (r_mask == '0) begin
                r_blk_bits <= r_acc + 10'(r_pk_len);
                r_acc      <= '0;
            end else begin
                r_acc <= r_acc + 10'(r_pk_len);
            end
        end
    end

    assign blk_bits   = r_blk_bits;
    assign total_bits = r_tot;
`endif

    assign enc_ready = r_rdy;
    assign pk_valid  = r_pk_valid;
    assign pk_code   = r_pk_code;
    assign pk_len    = r_pk_len;
    assign blk_done  = r_done;
    assign blk_x     = r_bx;
    assign blk_y     = r_by;

endmodule

// File: tb/tb_cavlc_field_sched.sv
// Scoreboard bench for cavlc_field_sched: a field-list model feeds queues, a monitor checks the packer port.
module tb_cavlc_field_sched;

    localparam int CODE_W = 50;
    localparam int LEN_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enc_valid = 1'b0;
    logic              enc_ready;
    logic [9:0]        topleft_x = '0;
    logic [9:0]        topleft_y = '0;
    logic [15:0]       ct_code = '0;
    logic [4:0]        ct_bit = '0;
    logic              ct_vld = 1'b0;
    logic [2:0]        t1_code = '0;
    logic [3:0]        t1_bit = '0;
    logic              t1_vld = 1'b0;
    logic [49:0]       lv_code = '0;
    logic [5:0]        lv_bit = '0;
    logic              lv_vld = 1'b0;
    logic [8:0]        tz_code = '0;
    logic [3:0]        tz_bit = '0;
    logic              tz_vld = 1'b0;
    logic [24:0]       rb_code = '0;
    logic [4:0]        rb_bit = '0;
    logic              rb_vld = 1'b0;
    logic              pk_valid;
    logic              pk_ready = 1'b0;
    logic [CODE_W-1:0] pk_code;
    logic [LEN_W-1:0]  pk_len;
    logic              blk_done;
    logic [9:0]        blk_x;
    logic [9:0]        blk_y;
`ifdef CAVLC_FIELD_BITCNT_EN
    logic [9:0]        blk_bits;
    logic [31:0]       total_bits;
`endif

    always #5 clk = ~clk;

    cavlc_field_sched #(.CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .enc_valid(enc_valid), .enc_ready(enc_ready),
        .topleft_x(topleft_x), .topleft_y(topleft_y),
        .ct_code(ct_code), .ct_bit(ct_bit), .ct_vld(ct_vld),
        .t1_code(t1_code), .t1_bit(t1_bit), .t1_vld(t1_vld),
        .lv_code(lv_code), .lv_bit(lv_bit), .lv_vld(lv_vld),
        .tz_code(tz_code), .tz_bit(tz_bit), .tz_vld(tz_vld),
        .rb_code(rb_code), .rb_bit(rb_bit), .rb_vld(rb_vld),
        .pk_valid(pk_valid), .pk_ready(pk_ready),
        .pk_code(pk_code), .pk_len(pk_len),
        .blk_done(blk_done), .blk_x(blk_x), .blk_y(blk_y)
`ifdef CAVLC_FIELD_BITCNT_EN
        , .blk_bits(blk_bits), .total_bits(total_bits)
`endif
    );

    typedef struct {
        logic [49:0] code;
        logic [5:0]  len;
        bit          first;
        bit          last;
        int          cap;
    } fld_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        int         bits;
        int         nf;
        int         cap;
    } blk_t;

    fld_t        qf[$];
    blk_t        qb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          exp_valid = 1'b0;
    bit          seen = 1'b0;
    int          pend_done = -1;
    int          last_cap = -1;
    int          gap = 0;
    bit          cap_done = 1'b0;
    int          pk_mode = 0;
    int          sc = 0;
    logic [31:0] m_tot = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: the block becomes the ordered list of its present fields.
    task automatic model_capture();
        logic [49:0] c[5];
        logic [5:0]  l[5];
        bit          v[5];
        int          idx[$];
        int          sum;
        blk_t        b;
        fld_t        f;
        c[0] = 50'(ct_code); l[0] = 6'(ct_bit); v[0] = ct_vld;
        c[1] = 50'(t1_code); l[1] = 6'(t1_bit); v[1] = t1_vld;
        c[2] = lv_code;      l[2] = lv_bit;     v[2] = lv_vld;
        c[3] = 50'(tz_code); l[3] = 6'(tz_bit); v[3] = tz_vld;
        c[4] = 50'(rb_code); l[4] = 6'(rb_bit); v[4] = rb_vld;
        sum = 0;
        for (int i = 0; i < 5; i++)
            if (v[i] && l[i] != 0) idx.push_back(i);
        for (int k = 0; k < idx.size(); k++) begin
            f.code  = c[idx[k]];
            f.len   = l[idx[k]];
            f.first = (k == 0);
            f.last  = (k == idx.size() - 1);
            f.cap   = cyc;
            sum += int'(l[idx[k]]);
            qf.push_back(f);
        end
        b.x = topleft_x; b.y = topleft_y; b.bits = sum;
        b.nf = idx.size(); b.cap = cyc;
        qb.push_back(b);
    endtask

    always @(negedge clk) begin
        blk_t b;
        fld_t f;
        if (mon_en) begin
            if (blk_done) begin
                if (qb.size() == 0) flag("done_unexpected");
                else begin
                    b = qb.pop_front();
                    chk("blk_x", 64'(blk_x), 64'(b.x));
                    chk("blk_y", 64'(blk_y), 64'(b.y));
                    chk("done_cycle", 64'(cyc), 64'((b.nf == 0) ? b.cap + 1 : pend_done));
                    chk("ready_at_done", 64'(enc_ready), 64'd1);
`ifdef CAVLC_FIELD_BITCNT_EN
                    m_tot = m_tot + 32'(b.bits);
                    chk("blk_bits", 64'(blk_bits), 64'(b.bits));
                    chk("total_bits", 64'(total_bits), 64'(m_tot));
`endif
                    pend_done = -1;
                end
            end else if (qb.size() > 0 &&
                         ((qb[0].nf == 0 && cyc == qb[0].cap + 1) || pend_done == cyc)) begin
                flag("done_missing");
                void'(qb.pop_front());
                pend_done = -1;
            end
            if (exp_valid) chk("no_bubble", 64'(pk_valid), 64'd1);
            exp_valid = 1'b0;
            if (pk_valid) begin
                chk("ready_low_busy", 64'(enc_ready), 64'd0);
                if (qf.size() == 0) flag("pk_unexpected");
                else begin
                    f = qf[0];
                    chk("pk_code", 64'(pk_code), 64'(f.code));
                    chk("pk_len", 64'(pk_len), 64'(f.len));
                    if (f.first && !seen) chk("first_latency", 64'(cyc), 64'(f.cap + 1));
                    seen = 1'b1;
                    if (pk_ready) begin
                        void'(qf.pop_front());
                        seen = 1'b0;
                        if (f.last) pend_done = cyc + 1;
                        else exp_valid = 1'b1;
                    end
                end
            end
            if (enc_valid && enc_ready) begin
                cap_done = blk_done;
                gap = (last_cap >= 0) ? cyc - last_cap : 0;
                last_cap = cyc;
                model_capture();
            end
        end
    end

    // pk_ready policy: 0 always ready, 1 random, 2 stall twice then accept each field
    always @(posedge clk) begin
        #1;
        if (pk_mode == 0) pk_ready = 1'b1;
        else if (pk_mode == 1) pk_ready = 1'($urandom_range(0, 1));
        else if (pk_valid) begin
            pk_ready = (sc == 2);
            sc = pk_ready ? 0 : sc + 1;
        end else begin
            pk_ready = 1'b0;
            sc = 0;
        end
    end

    task automatic send(input bit keep);
        bit ok;
        ok = 1'b0;
        enc_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (enc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("capture_timeout");
        @(posedge clk);
        #1;
        if (!keep) enc_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (qf.size() == 0 && qb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("drain_timeout");
        #1;
    endtask

    task automatic set_fields(input bit cv, input int cb, input bit tv, input int tb,
                              input bit lvv, input int lb, input bit zv, input int zb,
                              input bit rv, input int rbb);
        logic [63:0] r;
        ct_vld = cv;  ct_bit = 5'(cb);
        t1_vld = tv;  t1_bit = 4'(tb);
        lv_vld = lvv; lv_bit = 6'(lb);
        tz_vld = zv;  tz_bit = 4'(zb);
        rb_vld = rv;  rb_bit = 5'(rbb);
        r = {$urandom, $urandom};
        ct_code = 16'(r & ((64'd1 << cb) - 64'd1));
        t1_code = 3'(r & ((64'd1 << tb) - 64'd1));
        r = {$urandom, $urandom};
        lv_code = 50'(r & ((64'd1 << lb) - 64'd1));
        tz_code = 9'(r & ((64'd1 << zb) - 64'd1));
        rb_code = 25'(r & ((64'd1 << rbb) - 64'd1));
        topleft_x = 10'($urandom);
        topleft_y = 10'($urandom);
    endtask

    task automatic set_rand();
        set_fields($urandom_range(0, 3) != 0, $urandom_range(0, 16),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 50),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 9),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 25));
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc_ready", 64'(enc_ready), 64'd0);
        chk("rst_pk_valid", 64'(pk_valid), 64'd0);
        chk("rst_pk_code", 64'(pk_code), 64'd0);
        chk("rst_pk_len", 64'(pk_len), 64'd0);
        chk("rst_blk_done", 64'(blk_done), 64'd0);
        chk("rst_blk_xy", 64'({blk_x, blk_y}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(enc_ready), 64'd1);

        // all five present, fixed lengths, packer always ready
        pk_mode = 0;
        set_fields(1, 5, 1, 2, 1, 7, 1, 3, 1, 4);
        ct_code = 16'h03;
        t1_code = 3'b010;
        send(0);
        drain();

        // only coeff_token; zero-length t1 is skipped
        set_fields(1, 1, 1, 0, 0, 7, 0, 3, 0, 4);
        ct_code = 16'h1;
        send(0);
        drain();

        // stall pattern 0,0,1 per field
        pk_mode = 2;
        set_fields(1, 9, 1, 3, 1, 30, 0, 5, 1, 11);
        send(0);
        drain();
        set_fields(0, 4, 1, 1, 1, 50, 1, 9, 1, 25);
        send(0);
        drain();

        // empty block then a back-to-back capture
        pk_mode = 0;
        set_fields(0, 3, 0, 2, 0, 5, 0, 4, 0, 6);
        topleft_x = 10'd16;
        topleft_y = 10'd32;
        send(0);
        set_fields(1, 6, 0, 0, 1, 12, 0, 0, 1, 3);
        send(0);
        chk("empty_then_capture_gap", 64'(gap), 64'd1);
        drain();

        // enc_valid held across two blocks
        pk_mode = 1;
        set_fields(1, 7, 1, 2, 1, 20, 1, 6, 0, 0);
        send(1);
        set_fields(1, 2, 0, 0, 1, 8, 1, 2, 1, 5);
        send(0);
        chk("hold_capture_in_done", 64'(cap_done), 64'd1);
        drain();

        // reset while LV is on the packer port
        pk_mode = 0;
        set_fields(1, 5, 1, 2, 1, 7, 1, 3, 1, 4);
        send(0);
        begin : wait_lv
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (pk_valid && pk_len == 6'd7) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) flag("lv_wait_timeout");
        end
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_pk_valid", 64'(pk_valid), 64'd0);
        chk("midrst_enc_ready", 64'(enc_ready), 64'd0);
        qf.delete();
        qb.delete();
        exp_valid = 1'b0;
        seen = 1'b0;
        pend_done = -1;
        last_cap = -1;
        m_tot = '0;
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", 64'(enc_ready), 64'd1);
`ifdef CAVLC_FIELD_BITCNT_EN
        chk("midrst_total_bits", 64'(total_bits), 64'd0);
`endif
        repeat (8) @(posedge clk);
        #1;

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            pk_mode = $urandom_range(0, 2);
            set_rand();
            send($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        enc_valid = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(qf.size() + qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
